coeff_loader: RTL and testbench

COEFF_LOADER -- requirements
Module: coeff_loader

---
 rtl/coeff_pkg.sv | 7 +
 rtl/coeff_loader.sv | 72 +++++++
 tb/tb_coeff_loader.sv | 136 +++++++++++++
 3 files changed

// File: rtl/coeff_pkg.sv
// coeff_pkg: shared sizes and FSM state encoding for the coefficient loader
package coeff_pkg;
  localparam int NUM_COEFF = 11;
  localparam int COEFF_W = 32;
  localparam int IDX_W = 4;
  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_e;
endpackage

// File: rtl/coeff_loader.sv
// coeff_loader: shadow-buffered coefficient load (load_start, din/din_valid/din_ready in) committed atomically to coeffN_reg, with busy and load_done status
module coeff_loader
  import coeff_pkg::*;
#(
  parameter int NUM_COEFF = coeff_pkg::NUM_COEFF,
  parameter int COEFF_W = coeff_pkg::COEFF_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_start,
  input  logic               din_valid,
  input  logic [COEFF_W-1:0] din,
  output logic               din_ready,
  output logic [COEFF_W-1:0] coeff0_reg,
  output logic [COEFF_W-1:0] coeff1_reg,
  output logic [COEFF_W-1:0] coeff2_reg,
  output logic [COEFF_W-1:0] coeff3_reg,
  output logic [COEFF_W-1:0] coeff4_reg,
  output logic [COEFF_W-1:0] coeff5_reg,
  output logic [COEFF_W-1:0] coeff6_reg,
  output logic [COEFF_W-1:0] coeff7_reg,
  output logic [COEFF_W-1:0] coeff8_reg,
  output logic [COEFF_W-1:0] coeff9_reg,
  output logic [COEFF_W-1:0] coeff10_reg,
  output logic               busy,
  output logic               load_done
);
  state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [COEFF_W-1:0] shadow_q [NUM_COEFF];
  logic [COEFF_W-1:0] active_q [NUM_COEFF];
  logic din_ready_q, load_done_q, accept, last;
  always_comb begin
    accept = state_q == LOAD && din_ready_q && din_valid && !load_start;
    last = idx_q == IDX_W'(NUM_COEFF - 1);
    state_d = state_q == IDLE ? (load_start ? LOAD : IDLE) :
              state_q == LOAD ? (accept && last ? COMMIT : LOAD) : IDLE;
    idx_d = load_start && state_q != COMMIT ? '0 :
            accept && !last ? idx_q + 1'b1 : idx_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      din_ready_q <= 1'b0;
      load_done_q <= 1'b0;
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      din_ready_q <= state_d == LOAD;
      load_done_q <= state_q == COMMIT;
      if (accept) shadow_q[idx_q] <= din;
      if (state_q == COMMIT) active_q <= shadow_q;
    end
  end
  assign din_ready = din_ready_q;
  assign busy = state_q != IDLE;
  assign load_done = load_done_q;
  assign coeff0_reg = active_q[0];
  assign coeff1_reg = active_q[1];
  assign coeff2_reg = active_q[2];
  assign coeff3_reg = active_q[3];
  assign coeff4_reg = active_q[4];
  assign coeff5_reg = active_q[5];
  assign coeff6_reg = active_q[6];
  assign coeff7_reg = active_q[7];
  assign coeff8_reg = active_q[8];
  assign coeff9_reg = active_q[9];
  assign coeff10_reg = active_q[10];
endmodule

// File: tb/tb_coeff_loader.sv
// tb_coeff_loader: directed and random stimulus checked against a queue-based reference model
module tb_coeff_loader;
  import coeff_pkg::*;
  localparam int N = NUM_COEFF;
  localparam int W = COEFF_W;
  logic clk = 1'b0, rst = 1'b1, load_start = 1'b0, din_valid = 1'b0;
  logic [W-1:0] din = '0;
  logic din_ready, busy, load_done;
  logic [W-1:0] dut_c [N];
  int n_checks = 0, n_fail = 0;
  bit m_loading, m_commit, m_done;
  logic [W-1:0] m_q [$];
  logic [W-1:0] m_active [N];
  always #5 clk = ~clk;
  coeff_loader dut (
    .clk(clk), .rst(rst), .load_start(load_start), .din_valid(din_valid), .din(din),
    .din_ready(din_ready),
    .coeff0_reg(dut_c[0]), .coeff1_reg(dut_c[1]), .coeff2_reg(dut_c[2]), .coeff3_reg(dut_c[3]),
    .coeff4_reg(dut_c[4]), .coeff5_reg(dut_c[5]), .coeff6_reg(dut_c[6]), .coeff7_reg(dut_c[7]),
    .coeff8_reg(dut_c[8]), .coeff9_reg(dut_c[9]), .coeff10_reg(dut_c[10]),
    .busy(busy), .load_done(load_done)
  );
  task automatic check(string tag, logic [W-1:0] got, logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_edge();
    if (rst) begin
      m_loading = 0;
      m_commit = 0;
      m_done = 0;
      m_q.delete();
      foreach (m_active[i]) m_active[i] = '0;
    end else begin
      m_done = m_commit;
      if (m_commit) begin
        foreach (m_active[i]) m_active[i] = m_q[i];
        m_commit = 0;
      end else if (m_loading) begin
        if (load_start) m_q.delete();
        else if (din_valid) begin
          m_q.push_back(din);
          if (m_q.size() == N) begin
            m_loading = 0;
            m_commit = 1;
          end
        end
      end else if (load_start) begin
        m_loading = 1;
        m_q.delete();
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("din_ready", W'(din_ready), W'(m_loading));
    check("busy", W'(busy), W'(m_loading | m_commit));
    check("load_done", W'(load_done), W'(m_done));
    for (int i = 0; i < N; i++) check($sformatf("coeff%0d", i), dut_c[i], m_active[i]);
  endtask
  task automatic drive(bit ls, bit v, logic [W-1:0] d);
    load_start = ls;
    din_valid = v;
    din = d;
    tick();
  endtask
  task automatic check_bank(string tag, int base);
    for (int i = 0; i < N; i++) check($sformatf("%s_c%0d", tag, i), dut_c[i], W'(base + i));
  endtask
  task automatic full_load(int base);
    drive(1, 0, '0);
    for (int i = 0; i < N; i++) drive(0, 1, W'(base + i));
  endtask
  initial begin
    drive(0, 0, '0);
    drive(0, 1, W'(32'h55));
    rst = 1'b0;
    for (int i = 0; i < N; i++) check($sformatf("rst_c%0d", i), dut_c[i], '0);
    check("rst_ready", W'(din_ready), '0);
    full_load('h100);
    check("full_pre_done", W'(load_done), '0);
    check("full_pre_c0", dut_c[0], '0);
    drive(0, 0, '0);
    check("full_done", W'(load_done), W'(1));
    check_bank("full", 'h100);
    drive(0, 0, '0);
    check("full_done_gone", W'(load_done), '0);
    drive(1, 0, '0);
    for (int i = 0, t = 1; i < N; t ^= 1) begin
      drive(0, t[0], t[0] ? W'('h100 + i) : W'(32'hBAD));
      check("throttle_busy", W'(busy), W'(1));
      if (t[0]) i++;
    end
    drive(0, 0, '0);
    check_bank("throttle", 'h100);
    drive(1, 0, '0);
    for (int i = 0; i < 5; i++) drive(0, 1, W'($urandom));
    drive(1, 1, W'(32'hDEAD));
    check_bank("restart_hold", 'h100);
    for (int i = 0; i < N; i++) drive(0, 1, W'('h200 + i));
    drive(0, 0, '0);
    check_bank("restart", 'h200);
    repeat (3) drive(0, 1, W'($urandom));
    check_bank("idle_valid", 'h200);
    full_load('h300);
    drive(1, 1, W'($urandom));
    check("commit_ls_done", W'(load_done), W'(1));
    check("commit_ls_busy", W'(busy), '0);
    check_bank("commit_ls", 'h300);
    drive(1, 0, '0);
    check("start_on_done", W'(din_ready), W'(1));
    for (int i = 0; i < N; i++) drive(0, 1, W'('h400 + i));
    drive(0, 0, '0);
    check_bank("after_done_start", 'h400);
    drive(1, 0, '0);
    for (int i = 0; i < 7; i++) drive(0, 1, W'($urandom));
    rst = 1'b1;
    drive(0, 1, W'($urandom));
    rst = 1'b0;
    for (int i = 0; i < N; i++) check($sformatf("midrst_c%0d", i), dut_c[i], '0);
    check("midrst_ready", W'(din_ready), '0);
    repeat (15) drive(0, 1, W'($urandom));
    repeat (3000) begin
      rst = ($urandom % 300) == 0;
      drive(($urandom % 25) == 0, $urandom % 2 == 1, W'($urandom));
    end
    rst = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
